// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared FSM encoding, WB control bit indices and address-width helper for mem_stage.
package mem_stage_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/mem_stage_data_mem.sv
// data_mem: single-port word array, combinational read, synchronous write; contents are not reset.
module data_mem #(
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];
  assign rdata_o = mem_q[addr_i];
  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= wdata_i;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS EX/MEM + MEM/WB registers, branch resolve and wait-state data memory access.
// Optional MEM_ALIGN_CHECK_EN: flags misaligned accesses, suppresses their stores and zeroes their loads.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_ctlout,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] EX_MEM_NPC,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  five_bit_muxout,
  output logic        stall,
  output logic        pcsrc,
  output logic [31:0] pc_branch,
  output logic [1:0]  wb_ctl_wb,
  output logic [31:0] read_data,
  output logic [31:0] mem_alu_result,
  output logic [4:0]  mem_write_reg,
  output logic        misaligned
);
  localparam int AW = addr_w(MEM_DEPTH);
  // The IDLE cycle that raises stall counts as the first stall cycle, so WAIT covers the rest.
  localparam logic [3:0] CNT_LOAD = WAIT_STATES > 1 ? 4'(WAIT_STATES - 2) : 4'd0;
  logic [1:0]  wb_q, state_q, state_d, wbo_q;
  logic        branch_q, memread_q, memwrite_q, zero_q;
  logic [31:0] npc_q, alu_q, wdata_q, rdo_q, alo_q;
  logic [4:0]  dst_q, dsto_q;
  logic [3:0]  cnt_q, cnt_d;
  logic        mem_op, start, we;
  logic [31:0] mem_rd, rdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb_q       <= '0;
      branch_q   <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      npc_q      <= '0;
      zero_q     <= 1'b0;
      alu_q      <= '0;
      wdata_q    <= '0;
      dst_q      <= '0;
    end else if (!stall) begin
      wb_q       <= wb_ctlout;
      branch_q   <= branch;
      memread_q  <= memread;
      memwrite_q <= memwrite;
      npc_q      <= EX_MEM_NPC;
      zero_q     <= zero;
      alu_q      <= alu_result;
      wdata_q    <= rdata2out;
      dst_q      <= five_bit_muxout;
    end
  assign pcsrc     = branch_q & zero_q;
  assign pc_branch = npc_q;
  assign mem_op    = memread_q | memwrite_q;
  assign start     = state_q == S_IDLE && mem_op && WAIT_STATES > 0;
  assign stall     = start || state_q == S_WAIT;
  always_comb begin
    state_d = start ? (WAIT_STATES > 1 ? S_WAIT : S_DONE) :
              state_q == S_WAIT ? (cnt_q == 4'd0 ? S_DONE : S_WAIT) : S_IDLE;
    cnt_d   = start ? CNT_LOAD : (state_q == S_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
`ifdef MEM_ALIGN_CHECK_EN
  logic bad, mis_q;
  assign bad        = mem_op & |alu_q[1:0];
  assign we         = memwrite_q & ~stall & ~bad;
  assign rdata      = bad ? 32'd0 : mem_rd;
  assign misaligned = mis_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mis_q <= 1'b0;
    else if (!stall && bad) mis_q <= 1'b1;
`else
  assign we         = memwrite_q & ~stall;
  assign rdata      = mem_rd;
  assign misaligned = 1'b0;
`endif
  data_mem #(.DEPTH(MEM_DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (we),
    .addr_i  (alu_q[AW+1:2]),
    .wdata_i (wdata_q),
    .rdata_o (mem_rd)
  );
  // Stall cycles push bubbles into MEM/WB; the completing edge delivers the result.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wbo_q  <= '0;
      rdo_q  <= '0;
      alo_q  <= '0;
      dsto_q <= '0;
    end else begin
      wbo_q  <= stall ? 2'd0 : wb_q;
      rdo_q  <= stall ? 32'd0 : rdata;
      alo_q  <= stall ? 32'd0 : alu_q;
      dsto_q <= stall ? 5'd0 : dst_q;
    end
  assign wb_ctl_wb      = wbo_q;
  assign read_data      = rdo_q;
  assign mem_alu_result = alo_q;
  assign mem_write_reg  = dsto_q;
endmodule
